// File: rtl/input_loop_ctrl_if.sv
// Handshake and data bundle between input_loop_ctrl and its datapath/host.
// Floating-point values are carried as IEEE-754 binary32 bit patterns.
interface input_loop_ctrl_if #(
  parameter int Tn_p    = 1,
  parameter int CNT_W_p = 16
);
  logic               start_i;
  logic [CNT_W_p-1:0] n_i;
  logic [31:0]        bias_i;
  logic               data_valid_i;
  logic [31:0]        fm_sum_i;
  logic               result_ready_i;
  logic               busy_o;
  logic [CNT_W_p-1:0] tile_base_o;
  logic [Tn_p-1:0]    lane_valid_o;
  logic [31:0]        fm_init_o;
  logic [31:0]        result_o;
  logic               result_valid_o;

  modport slave (
    input  start_i, n_i, bias_i, data_valid_i, fm_sum_i, result_ready_i,
    output busy_o, tile_base_o, lane_valid_o, fm_init_o, result_o, result_valid_o
  );

  modport master (
    output start_i, n_i, bias_i, data_valid_i, fm_sum_i, result_ready_i,
    input  busy_o, tile_base_o, lane_valid_o, fm_init_o, result_o, result_valid_o
  );
endinterface

// File: rtl/input_loop_ctrl.sv
// Tile sequencer for the input_loop datapath: walks N channels Tn_p at a time and
// accumulates binary32 partial sums. INPUT_LOOP_CTRL_RELU_EN applies ReLU to result_o.
module input_loop_ctrl #(
  parameter int Tn_p    = 1,
  parameter int CNT_W_p = 16
) (
  input logic              clk_i,
  input logic              rst_n_i,
  input_loop_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  localparam logic [CNT_W_p:0] TN_EXT = (CNT_W_p+1)'(Tn_p);

  logic [1:0]         state_q, state_d;
  logic [CNT_W_p-1:0] n_q, n_d;
  logic [CNT_W_p-1:0] base_q, base_d;
  logic [31:0]        bias_q, bias_d;
  logic [31:0]        acc_q, acc_d;
  logic               first_q, first_d;

  // One bit wider than the counters so the last-tile test never wraps.
  logic [CNT_W_p:0]   base_next;
  logic               last_tile;
  logic [Tn_p-1:0]    lane_valid;

  function automatic logic [31:0] relu_f(input logic [31:0] v);
`ifdef INPUT_LOOP_CTRL_RELU_EN
    return (v[31] && (|v[30:0])) ? 32'h0000_0000 : v;
`else
    return v;
`endif
  endfunction

  assign base_next = {1'b0, base_q} + TN_EXT;
  assign last_tile = (base_next >= {1'b0, n_q});

  always_comb begin
    lane_valid = '0;
    for (int j = 0; j < Tn_p; j++) begin
      lane_valid[j] = (state_q == ST_RUN) &&
                      (({1'b0, base_q} + (CNT_W_p+1)'(j)) < {1'b0, n_q});
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    bias_d  = bias_q;
    base_d  = base_q;
    acc_d   = acc_q;
    first_d = first_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          n_d     = bus.n_i;
          bias_d  = bus.bias_i;
          base_d  = '0;
          first_d = 1'b1;
          if (bus.n_i != '0) begin
            state_d = ST_RUN;
          end else begin
            // Zero channels: the result is the bias itself.
            acc_d   = bus.bias_i;
            state_d = ST_OUT;
          end
        end
      end
      ST_RUN: begin
        if (bus.data_valid_i) begin
          acc_d   = bus.fm_sum_i;
          first_d = 1'b0;
          base_d  = base_next[CNT_W_p-1:0];
          if (last_tile) state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (bus.result_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      base_q  <= '0;
      bias_q  <= '0;
      acc_q   <= '0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      base_q  <= base_d;
      bias_q  <= bias_d;
      acc_q   <= acc_d;
      first_q <= first_d;
    end
  end

  assign bus.busy_o         = (state_q != ST_IDLE);
  assign bus.tile_base_o    = base_q;
  assign bus.lane_valid_o   = lane_valid;
  assign bus.fm_init_o      = first_q ? bias_q : acc_q;
  assign bus.result_o       = relu_f(acc_q);
  assign bus.result_valid_o = (state_q == ST_OUT);

endmodule

// File: doc/input_loop_ctrl.md
INPUT_LOOP_CTRL -- requirements
Module: input_loop_ctrl

Interface
REQ-001 The block SHALL have parameter Tn_p, default 1: number of parallel multiply lanes in the driven input_loop datapath.
REQ-002 The block SHALL have parameter CNT_W_p, default 16: width of the channel count and channel index.
REQ-003 The block SHALL use one clock, clk_i, and an asynchronous active-low reset, rst_n_i.
REQ-004 clk_i  input  1  clock; all state updates on rising edge.
REQ-005 rst_n_i  input  1  asynchronous active-low reset.
REQ-006 start_i  input  1  start request; accepted only in IDLE.
REQ-007 n_i  input  CNT_W_p  number of input channels N; sampled on start acceptance.
REQ-008 bias_i  input  shortreal  initial output value; sampled on start acceptance.
REQ-009 data_valid_i  input  1  fm/weight buffers present valid data for tile_base_o.
REQ-010 fm_sum_i  input  shortreal  datapath result: sum of lane products plus fm_init_o.
REQ-011 result_ready_i  input  1  downstream accepts result_o.
REQ-012 busy_o  output  1  high in RUN and OUT.
REQ-013 tile_base_o  output  CNT_W_p  first channel index of the current tile (buffer address).
REQ-014 lane_valid_o  output  Tn_p  per-lane enable; the datapath wrapper zeroes disabled lanes.
REQ-015 fm_init_o  output  shortreal  value driven to the datapath's fm_init_i.
REQ-016 result_o  output  shortreal  final accumulated output.
REQ-017 result_valid_o  output  1  result_o is valid.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, OUT.
REQ-019 IDLE with start_i=1: latch n_q=n_i, bias_q=bias_i, base_q=0, first_q=1; go to RUN if n_i!=0, else load acc_q=bias_i and go to OUT.
REQ-020 start_i in RUN or OUT SHALL be ignored, with no change to latched values.
REQ-021 RUN, data_valid_i=1: acc_q<=fm_sum_i, first_q<=0, base_q<=base_q+Tn_p; go to OUT if base_q+Tn_p>=n_q (computed at CNT_W_p+1 bits, no wrap).
REQ-022 RUN, data_valid_i=0: all state held (stall); no accumulation.
REQ-023 fm_init_o SHALL equal bias_q when first_q=1, else acc_q.
REQ-024 tile_base_o SHALL equal base_q; lane_valid_o[j] SHALL be 1 iff base_q+j<n_q (CNT_W_p+1-bit compare), 0 outside RUN.
REQ-025 OUT: result_valid_o=1, result_o=acc_q (per REQ-033); on result_ready_i=1 go to IDLE the next cycle.
REQ-026 result_o and result_valid_o SHALL hold stable while result_ready_i=0.
REQ-027 Tile throughput SHALL be one tile per cycle with data_valid_i held high; total RUN cycles = ceil(N/Tn_p).
REQ-028 result_valid_o SHALL rise the cycle after the last accepted tile.

Reset
REQ-029 rst_n_i=0 SHALL force IDLE immediately regardless of state, including mid-RUN, abandoning any partial accumulation.
REQ-030 Reset values: busy_o=0, result_valid_o=0, tile_base_o=0, lane_valid_o=0, fm_init_o=0.0, result_o=0.0, acc_q=0.0, bias_q=0.0, n_q=0, first_q=1.
REQ-031 The first start after reset release SHALL behave identically to any other start.

Configuration
REQ-032 Macro INPUT_LOOP_CTRL_RELU_EN SHALL select ReLU on the final result.
REQ-033 Defined: result_o=(acc_q<0.0)?0.0:acc_q; undefined: result_o=acc_q; fm_init_o and intermediate accumulation SHALL be unaffected either way.

Verification
REQ-034 Tn_p=3, N=3, bias 0, fm {7.2,5,20}, weights 10 -> one RUN cycle, lane_valid 3'b111, result_o=322.0, result_valid_o one cycle after data_valid_i.
REQ-035 Tn_p=3, N=7, bias 1.5, all fm 1.0, weights 2.0 -> tile_base 0,3,6; lane_valid 111,111,001; fm_init 1.5 then accumulated; result_o=15.5.
REQ-036 N=0, bias 2.25 -> no RUN cycles, lane_valid stays 0, result_o=2.25 valid the cycle after start.
REQ-037 N=6, Tn_p=3, data_valid_i low 2 cycles between tiles and result_ready_i low 3 cycles, start_i pulsed while busy -> tile_base holds during stall, result held, start ignored, single correct result.
REQ-038 rst_n_i low mid-RUN after tile 0 (N=9) -> busy_o=0, outputs at reset values immediately; new start with N=3 gives result from bias only.
REQ-039 bias -10.0, N=3, Tn_p=3, products sum 6.0 -> result_o=0.0 with INPUT_LOOP_CTRL_RELU_EN defined, -4.0 without.
